avalon_speaker_tx: RTL and testbench
====================================

AVALON_SPEAKER_TX -- requirements
Module: avalon_speaker_tx

Interface
REQ-001 Parameter DATA_W, default 24: audio sample width per channel, in bits.
REQ-002 Parameter FIFO_DEPTH, default 8: number of stereo frames the FIFO holds; must be a power of two.
REQ-003 Port clk, input, 1: system clock; the only clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port enable, input, 1: transmit enable.
REQ-006 Port bclk_in, input, 1: I2S bit clock from the shared bclk PLL output; asynchronous to clk; at most clk/8.
REQ-007 Port lrclk_in, input, 1: I2S word-select clock; 0 = left, 1 = right; changes only on falling edges of bclk_in.
REQ-008 Port snk_data, input, 2*DATA_W: stereo frame; bits [2*DATA_W-1:DATA_W] = left, bits [DATA_W-1:0] = right.
REQ-009 Port snk_valid, input, 1: Avalon-ST valid.
REQ-010 Port snk_ready, output, 1: Avalon-ST ready.
REQ-011 Port dout, output, 1: I2S serial data to the DAC or amplifier.
REQ-012 Port fifo_level, output, log2(FIFO_DEPTH)+1: number of frames currently stored.
REQ-013 Port underrun_sticky, output, 1: set when an underrun occurs; stays set until cleared.
REQ-014 Port underrun_count, output, 16: number of underruns; saturates at 0xFFFF.
REQ-015 Port underrun_clr, input, 1: one-cycle pulse that clears underrun_sticky and underrun_count.

Function
REQ-016 bclk_in and lrclk_in SHALL each pass through a 2-flop synchronizer; a third flop on bclk SHALL provide rising- and falling-edge detect pulses, each one clk wide.
REQ-017 On each detected bclk rise, lr_r SHALL capture synchronized lrclk.
REQ-018 On each detected bclk fall where lr_r != lr_slot, a new slot starts:
- lr_slot <= lr_r;
- shift register loads the channel word (left when lr_r = 0, right when lr_r = 1);
- dout <= word MSB;
- bit_cnt <= 1.
This gives the standard I2S one-bclk delay: the MSB is driven on the first falling edge after the lrclk transition.
REQ-019 On each other bclk fall:
- if bit_cnt < DATA_W: dout <= next bit, MSB-first, and bit_cnt increments;
- otherwise dout <= 0, padding the slot to any length (32 bclk per slot nominal).
REQ-020 At a left-slot start with enable = 1 and FIFO non-empty, one frame SHALL be popped:
- its left half feeds the shift register;
- its right half is held for the following right slot.
REQ-021 At a left-slot start with enable = 1 and FIFO empty:
- left and held-right words are both 0;
- underrun_sticky <= 1;
- underrun_count increments, saturating at 0xFFFF.
REQ-022 At a right-slot start, the shift register SHALL load the held right word; no pop occurs.
REQ-023 With enable = 0:
- slot words are 0;
- no pops occur and no underruns are counted;
- slot tracking continues, so re-enabling takes effect at the next left-slot start, never mid-frame.
REQ-024 snk_ready = (fifo_level < FIFO_DEPTH) and not reset; a push occurs when snk_valid and snk_ready are both high.
REQ-025 A push and a pop in the same cycle SHALL leave fifo_level unchanged; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-026 When the FIFO is full, snk_ready is low even if a pop occurs in the same cycle; the frame is accepted on the following cycle.
REQ-027 If underrun_clr and an underrun occur in the same cycle, the underrun wins: sticky = 1, count = 1.
REQ-028 Total latency SHALL be: bclk fall at the input pin to dout change = 3 clk (2 synchronizer flops + 1 edge-detect/output register).

Reset
REQ-029 On reset, all of the following SHALL clear: dout = 0, fifo_level = 0, snk_ready = 0, underrun_sticky = 0, underrun_count = 0, shift register and held word = 0, bit_cnt = DATA_W, lr_slot = 1, lr_r = 1.
REQ-030 With these reset values, the first observed left slot is a valid slot start.
REQ-031 Reset asserted mid-slot SHALL abandon the slot and discard FIFO contents.
REQ-032 After reset, dout stays 0 until the first left-slot start.

Verification
REQ-033 Bench settings: clk 50 MHz, bclk 3.125 MHz, 32 bclk per slot, enable = 1.
- Push frame L = 0xA5A5A5, R = 0x3C3C3C.
- Required: dout carries 0xA5A5A5 MSB-first starting 1 bclk after lrclk falls, then 8 zero bits; the right slot carries 0x3C3C3C the same way.
REQ-034 Empty FIFO across 3 frames -> dout stays 0, underrun_count = 3, underrun_sticky = 1; one underrun_clr pulse -> both return to 0.
REQ-035 Push 9 frames back-to-back with snk_valid held high and no bclk -> fifo_level = 8 and snk_ready = 0; the 9th frame is accepted in the cycle after the first left-slot pop.
REQ-036 Deassert enable mid-left-slot with 2 frames queued -> the current slot completes, later slots are 0, fifo_level stays 2; re-enable -> the next left slot pops the frame with no underrun counted.
REQ-037 Assert reset mid-right-slot with 5 frames queued -> next cycle fifo_level = 0, dout = 0, snk_ready = 0; the first post-reset left slot with an empty FIFO counts underrun_count = 1.
REQ-038 Force 0xFFFF underruns -> underrun_count holds at 0xFFFF; underrun_clr in the same cycle as an underrun -> count = 1, sticky = 1.

Source files
------------

// File: rtl/avalon_speaker_tx.sv
// Avalon-ST stereo sink feeding an I2S transmitter slaved to an external bclk/lrclk.
// Frames are buffered in a small FIFO and popped one per left-slot start.
module avalon_speaker_tx #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          bclk_in,
  input  logic                          lrclk_in,
  input  logic [2*DATA_W-1:0]           snk_data,
  input  logic                          snk_valid,
  output logic                          snk_ready,
  output logic                          dout,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun_sticky,
  output logic [15:0]                   underrun_count,
  input  logic                          underrun_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);

  logic r_bclk_s1, r_bclk_s2, r_bclk_s3;
  logic r_lr_s1, r_lr_s2;
  logic r_lr_r, r_lr_slot;
  logic [DATA_W-1:0] r_shift, r_held;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_dout;

  logic [2*DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]    r_level;

  logic        r_sticky;
  logic [15:0] r_count;

  logic                w_bclk_rise, w_bclk_fall;
  logic                w_slot_start, w_left_start;
  logic                w_fifo_empty, w_pop, w_push, w_underrun;
  logic [2*DATA_W-1:0] w_head;
  logic [DATA_W-1:0]   w_word;

  assign w_bclk_rise  = r_bclk_s2 & ~r_bclk_s3;
  assign w_bclk_fall  = ~r_bclk_s2 & r_bclk_s3;
  assign w_slot_start = w_bclk_fall & (r_lr_r != r_lr_slot);
  assign w_left_start = w_slot_start & ~r_lr_r;
  assign w_fifo_empty = (r_level == '0);
  assign w_pop        = w_left_start & enable & ~w_fifo_empty;
  assign w_underrun   = w_left_start & enable & w_fifo_empty;
  assign w_push       = snk_valid & snk_ready;
  assign w_head       = r_mem[r_rd_ptr];

  // Word loaded at a slot start; disabled or starved slots play silence.
  always_comb begin
    w_word = '0;
    if (enable) begin
      if (r_lr_r)
        w_word = r_held;
      else if (!w_fifo_empty)
        w_word = w_head[2*DATA_W-1:DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bclk_s1 <= 1'b0;
      r_bclk_s2 <= 1'b0;
      r_bclk_s3 <= 1'b0;
      r_lr_s1   <= 1'b0;
      r_lr_s2   <= 1'b0;
    end else begin
      r_bclk_s1 <= bclk_in;
      r_bclk_s2 <= r_bclk_s1;
      r_bclk_s3 <= r_bclk_s2;
      r_lr_s1   <= lrclk_in;
      r_lr_s2   <= r_lr_s1;
    end
  end

  // lr_slot starts at 1 so that the first observed left slot is a fresh slot start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lr_r    <= 1'b1;
      r_lr_slot <= 1'b1;
      r_shift   <= '0;
      r_held    <= '0;
      r_bit_cnt <= CNT_MAX;
      r_dout    <= 1'b0;
    end else begin
      if (w_bclk_rise)
        r_lr_r <= r_lr_s2;
      if (w_slot_start) begin
        r_lr_slot <= r_lr_r;
        r_dout    <= w_word[DATA_W-1];
        r_shift   <= w_word << 1;
        r_bit_cnt <= CNT_W'(1);
        if (!r_lr_r)
          r_held <= w_pop ? w_head[DATA_W-1:0] : '0;
      end else if (w_bclk_fall) begin
        if (r_bit_cnt < CNT_MAX) begin
          r_dout    <= r_shift[DATA_W-1];
          r_shift   <= r_shift << 1;
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end else begin
          r_dout <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= snk_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // An underrun in the same cycle as a clear wins and restarts the count at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sticky <= 1'b0;
      r_count  <= '0;
    end else if (w_underrun) begin
      r_sticky <= 1'b1;
      if (underrun_clr)
        r_count <= 16'd1;
      else if (r_count != 16'hFFFF)
        r_count <= r_count + 16'd1;
    end else if (underrun_clr) begin
      r_sticky <= 1'b0;
      r_count  <= '0;
    end
  end

  assign snk_ready       = ~reset & (r_level < LVL_MAX);
  assign dout            = r_dout;
  assign fifo_level      = r_level;
  assign underrun_sticky = r_sticky;
  assign underrun_count  = r_count;

endmodule

// File: tb/tb_avalon_speaker_tx.sv
// Self-checking bench for avalon_speaker_tx: drives an I2S bclk/lrclk pattern and
// compares each recovered slot word against frames queued on the Avalon-ST side.
module tb_avalon_speaker_tx;
  localparam int DATA_W     = 24;
  localparam int FIFO_DEPTH = 8;
  localparam int FW         = 2 * DATA_W;

  logic          clk = 1'b0;
  logic          reset, enable, bclk_in, lrclk_in;
  logic [FW-1:0] snk_data;
  logic          snk_valid, snk_ready, dout;
  logic [3:0]    fifo_level;
  logic          underrun_sticky, underrun_clr;
  logic [15:0]   underrun_count;

  logic [FW-1:0]     exp_q[$];
  logic [DATA_W-1:0] m_held;
  logic [15:0]       m_count;
  logic              m_sticky;
  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk = ~clk;

  avalon_speaker_tx #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bclk_in(bclk_in), .lrclk_in(lrclk_in),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready), .dout(dout),
    .fifo_level(fifo_level), .underrun_sticky(underrun_sticky),
    .underrun_count(underrun_count), .underrun_clr(underrun_clr)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One bclk period (8 clk low, 8 clk high); dout is sampled just before the rise.
  task automatic bclk_cycle(input logic lr, input logic do_rst, input logic do_clr,
                            output logic s);
    @(negedge clk);
    bclk_in  = 1'b0;
    lrclk_in = lr;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      underrun_clr = (do_clr && k == 2);
      if (do_rst && k == 4) reset = 1'b1;
      if (do_rst && k == 5) begin
        n_tests++;
        if (fifo_level !== 4'd0) begin
          n_fail++; $display("FAIL rst_level: got %0d expected 0", fifo_level);
        end
        n_tests++;
        if (dout !== 1'b0) begin
          n_fail++; $display("FAIL rst_dout: got %b expected 0", dout);
        end
        n_tests++;
        if (snk_ready !== 1'b0) begin
          n_fail++; $display("FAIL rst_ready: got %b expected 0", snk_ready);
        end
        reset = 1'b0;
      end
    end
    s = dout;
    bclk_in = 1'b1;
    repeat (7) @(negedge clk);
  endtask

  task automatic push_frame(input logic [FW-1:0] d);
    int w = 0;
    @(negedge clk);
    snk_data  = d;
    snk_valid = 1'b1;
    while (snk_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    n_tests++;
    if (w >= 100) begin
      n_fail++; $display("FAIL push_timeout: ready stayed %b, expected 1", snk_ready);
    end else begin
      @(posedge clk);
      exp_q.push_back(d);
    end
  endtask

  // One stereo frame: left slot then right slot, 32 bclk each, with the expected
  // words taken from the scoreboard at each slot start.
  task automatic run_frame(input string tag, input int dis_bit, input int rst_bit,
                           input logic clr_at_start);
    logic [DATA_W-1:0] exp_l, exp_r;
    logic [DATA_W-1:0] got_l = '0;
    logic [DATA_W-1:0] got_r = '0;
    logic [FW-1:0]     f;
    logic pad = 1'b0;
    logic rst_done = 1'b0;
    logic ur = 1'b0;
    logic s;
    exp_l = '0;
    m_held = '0;
    if (enable) begin
      if (exp_q.size() > 0) begin
        f = exp_q.pop_front();
        exp_l  = f[FW-1:DATA_W];
        m_held = f[DATA_W-1:0];
      end else begin
        ur = 1'b1;
        m_sticky = 1'b1;
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
      end
    end
    if (clr_at_start) begin
      if (ur) m_count = 16'd1;
      else begin m_count = 16'd0; m_sticky = 1'b0; end
    end
    for (int b = 0; b < 32; b++) begin
      bclk_cycle(1'b0, 1'b0, clr_at_start && b == 1, s);
      if (b >= 1 && b <= DATA_W) got_l = {got_l[DATA_W-2:0], s};
      else pad = pad | s;
      if (b == dis_bit) enable = 1'b0;
    end
    exp_r = enable ? m_held : '0;
    for (int b = 0; b < 32; b++) begin
      bclk_cycle(1'b1, b == rst_bit, 1'b0, s);
      if (b == rst_bit) rst_done = 1'b1;
      if (!rst_done) begin
        if (b >= 1 && b <= DATA_W) got_r = {got_r[DATA_W-2:0], s};
        else pad = pad | s;
      end
    end
    n_tests++;
    if (got_l !== exp_l) begin
      n_fail++; $display("FAIL %s_left: got %h expected %h", tag, got_l, exp_l);
    end
    if (rst_done) begin
      exp_q.delete();
      m_count = 16'd0;
      m_sticky = 1'b0;
      m_held = '0;
    end else begin
      n_tests++;
      if (got_r !== exp_r) begin
        n_fail++; $display("FAIL %s_right: got %h expected %h", tag, got_r, exp_r);
      end
      n_tests++;
      if (pad !== 1'b0) begin
        n_fail++; $display("FAIL %s_pad: got %b expected 0", tag, pad);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; bclk_in = 1'b1; lrclk_in = 1'b1;
    snk_valid = 1'b0; snk_data = '0; underrun_clr = 1'b0;
    m_count = 16'd0; m_sticky = 1'b0; m_held = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (dout !== 1'b0) begin n_fail++; $display("FAIL reset_dout: got %b expected 0", dout); end
    n_tests++;
    if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    n_tests++;
    if (snk_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", snk_ready); end
    n_tests++;
    if (underrun_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_sticky: got %b expected 0", underrun_sticky); end
    n_tests++;
    if (underrun_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", underrun_count); end
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (snk_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b expected 1", snk_ready); end
  endtask

  task automatic test_basic();
    push_frame({24'hA5A5A5, 24'h3C3C3C});
    @(negedge clk); snk_valid = 1'b0;
    n_tests++;
    if (fifo_level !== 4'd1) begin n_fail++; $display("FAIL basic_level: got %0d expected 1", fifo_level); end
    run_frame("basic", -1, -1, 1'b0);
    n_tests++;
    if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL basic_drain: got %0d expected 0", fifo_level); end
    n_tests++;
    if (underrun_count !== 16'd0) begin n_fail++; $display("FAIL basic_count: got %0d expected 0", underrun_count); end
  endtask

  task automatic test_underrun();
    for (int i = 0; i < 3; i++) run_frame("underrun", -1, -1, 1'b0);
    n_tests++;
    if (underrun_count !== 16'd3) begin n_fail++; $display("FAIL ur_count: got %0d expected 3", underrun_count); end
    n_tests++;
    if (underrun_sticky !== 1'b1) begin n_fail++; $display("FAIL ur_sticky: got %b expected 1", underrun_sticky); end
    @(negedge clk); underrun_clr = 1'b1;
    @(negedge clk); underrun_clr = 1'b0;
    m_count = 16'd0; m_sticky = 1'b0;
    n_tests++;
    if (underrun_count !== 16'd0) begin n_fail++; $display("FAIL ur_clr_count: got %0d expected 0", underrun_count); end
    n_tests++;
    if (underrun_sticky !== 1'b0) begin n_fail++; $display("FAIL ur_clr_sticky: got %b expected 0", underrun_sticky); end
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] f9;
    for (int i = 0; i < 8; i++) begin
      logic [FW-1:0] f;
      f = {$urandom(), $urandom()};
      if (i == 0) f[FW-1] = 1'b1;
      push_frame(f);
    end
    f9 = {$urandom(), $urandom()};
    @(negedge clk);
    snk_data = f9;
    n_tests++;
    if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL b2b_full_level: got %0d expected 8", fifo_level); end
    n_tests++;
    if (snk_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got %b expected 0", snk_ready); end
    fork
      run_frame("b2b_first", -1, -1, 1'b0);
      begin
        int w = 0;
        while (snk_ready !== 1'b1 && w < 3000) begin
          @(negedge clk);
          w++;
        end
        n_tests++;
        if (w >= 3000) begin n_fail++; $display("FAIL b2b_ready_timeout: ready %b expected 1", snk_ready); end
        n_tests++;
        if (fifo_level !== 4'd7) begin n_fail++; $display("FAIL b2b_pop_level: got %0d expected 7", fifo_level); end
        n_tests++;
        if (dout !== 1'b1) begin n_fail++; $display("FAIL b2b_pop_dout: got %b expected 1", dout); end
        @(posedge clk);
        exp_q.push_back(f9);
        @(negedge clk);
        snk_valid = 1'b0;
        n_tests++;
        if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL b2b_accept: got %0d expected 8", fifo_level); end
      end
    join
    for (int i = 0; i < 8; i++) run_frame("b2b_drain", -1, -1, 1'b0);
    n_tests++;
    if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL b2b_empty: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_enable();
    for (int i = 0; i < 3; i++) push_frame({$urandom(), $urandom()});
    @(negedge clk); snk_valid = 1'b0;
    run_frame("en_cut", 10, -1, 1'b0);
    n_tests++;
    if (fifo_level !== 4'd2) begin n_fail++; $display("FAIL en_cut_level: got %0d expected 2", fifo_level); end
    run_frame("en_off", -1, -1, 1'b0);
    n_tests++;
    if (fifo_level !== 4'd2) begin n_fail++; $display("FAIL en_off_level: got %0d expected 2", fifo_level); end
    enable = 1'b1;
    run_frame("en_on", -1, -1, 1'b0);
    run_frame("en_on", -1, -1, 1'b0);
    n_tests++;
    if (underrun_count !== 16'd0) begin n_fail++; $display("FAIL en_count: got %0d expected 0", underrun_count); end
    n_tests++;
    if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL en_level: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_reset_mid_slot();
    for (int i = 0; i < 5; i++) push_frame({$urandom(), $urandom()});
    @(negedge clk); snk_valid = 1'b0;
    run_frame("rst_mid", -1, 10, 1'b0);
    run_frame("post_rst", -1, -1, 1'b0);
    n_tests++;
    if (underrun_count !== 16'd1) begin n_fail++; $display("FAIL post_rst_count: got %0d expected 1", underrun_count); end
    n_tests++;
    if (underrun_sticky !== 1'b1) begin n_fail++; $display("FAIL post_rst_sticky: got %b expected 1", underrun_sticky); end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    force dut.r_count = 16'hFFFD;
    @(negedge clk);
    release dut.r_count;
    m_count = 16'hFFFD;
    for (int i = 0; i < 3; i++) run_frame("sat", -1, -1, 1'b0);
    n_tests++;
    if (underrun_count !== m_count) begin n_fail++; $display("FAIL sat_count: got %h expected %h", underrun_count, m_count); end
    n_tests++;
    if (underrun_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h expected ffff", underrun_count); end
    run_frame("sat_clr", -1, -1, 1'b1);
    n_tests++;
    if (underrun_count !== 16'd1) begin n_fail++; $display("FAIL clr_race_count: got %0d expected 1", underrun_count); end
    n_tests++;
    if (underrun_sticky !== 1'b1) begin n_fail++; $display("FAIL clr_race_sticky: got %b expected 1", underrun_sticky); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_back_to_back();
    test_enable();
    test_reset_mid_slot();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
